lsu_mem_stage: RTL and testbench
================================

// Module: lsu_mem_stage
// PURPOSE
//  Memory-stage load/store unit; consumes the EX/MEM pipeline register outputs (preg_2_*).
//  Runs a req/ack transaction on the data-memory bus and formats load data for writeback.
//  Drives lsu_stall back to the pipeline-hold/flush logic while a transaction is in flight.
//  Supports byte, half and word accesses, plus misalignment and bus-timeout reporting.
// PARAMETERS
//  TIMEOUT_CYCLES  16  cycles in REQ without mem_ack before the bus error fires (>=2)
//  ADDR_W          32  address width; data width fixed at 32
// PORTS
//  clk            in   1   rising-edge clock
//  reset_n        in   1   asynchronous, active-low reset
//  preg_2_rd_en   in   1   load in MEM stage
//  preg_2_wr_en   in   1   store in MEM stage
//  preg_2_alu_out in   32  effective byte address
//  preg_2_rdata2  in   32  store data (rs2)
//  preg_2_inst    in   32  instruction; funct3=inst[14:12] gives size/sign
//  mem_req        out  1   bus request, held until mem_ack
//  mem_we         out  1   1=write
//  mem_addr       out  ADDR_W  word-aligned address ({addr[31:2],2'b00})
//  mem_wdata      out  32  store data replicated to the byte lanes
//  mem_wstrb      out  4   byte-lane strobes (0 on reads)
//  mem_ack        in   1   one-cycle completion; mem_rdata valid with it
//  mem_rdata      in   32  read word
//  lsu_rdata      out  32  aligned, extended load result, valid in DONE
//  lsu_stall      out  1   hold upstream stages
//  lsu_misalign   out  1   one-cycle pulse: misaligned access, no bus activity
//  lsu_err        out  1   one-cycle pulse: timeout or rd_en&wr_en both set
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; timeout counter 0. Async assert also clears mem_req
//   mid-transaction (the transfer is abandoned; the slave must tolerate it).
//  FSM IDLE->REQ->DONE->IDLE.
//  IDLE, new access (rd_en^wr_en), aligned:
//   - capture addr, wdata, wstrb, funct3, we into regs; state->REQ
//   - lsu_stall=1 combinationally in this cycle
//  Misaligned (half with addr[0]=1; word with addr[1:0]!=0):
//   - lsu_misalign=1 for this cycle; no mem_req, no stall; stay IDLE
//  rd_en&wr_en both set: lsu_err=1 for one cycle; no request; stay IDLE
//  REQ:
//   - mem_req=1; bus outputs come from the captured regs only
//   - lsu_stall=1; count cycles
//   - on mem_ack: loads capture the formatted mem_rdata into lsu_rdata; state->DONE
//   - counter reaches TIMEOUT_CYCLES without ack: drop mem_req, lsu_err=1, lsu_rdata=0,
//     state->DONE
//  DONE:
//   - lsu_stall=0; lsu_rdata holds the load value
//   - preg_2 still holds the completed instruction, so no new access is accepted here
//   - state->IDLE next cycle
//  Latency: ack in the first REQ cycle gives 2 stall cycles; result in DONE (3rd cycle).
//  Store lanes by funct3:
//   - SB(000): wdata={4{d[7:0]}}, wstrb=4'b0001<<a[1:0]
//   - SH(001): wdata={2{d[15:0]}}, wstrb=a[1]?1100:0011
//   - SW(010): wstrb=1111
//  Loads: LB(000)/LH(001) sign-extend; LBU(100)/LHU(101) zero-extend; LW(010) pass-through.
//   The lane is selected by the captured addr[1:0].
//  Undefined funct3: treated as the word variant.
//  mem_ack outside REQ is ignored. preg_2 inputs are ignored in REQ and DONE.
// STRUCTURE
//  lsu_pkg:
//   - lsu_state_e {IDLE,REQ,DONE}
//   - funct3 localparams (F3_B,F3_H,F3_W,F3_BU,F3_HU)
//   - function ret strb/wdata encode
//  Sub-module lsu_load_align: combinational (word, addr[1:0], funct3) -> 32b result.
// TESTING
//  1 SW addr 0x100 data 0xDEADBEEF, ack 1st REQ cycle
//    -> mem_addr 0x100, wstrb 1111, stall 2 cycles
//  2 SB addr 0x103 data 0x000000A5 -> wdata 0xA5A5A5A5, wstrb 1000
//  3 LB addr 0x202, rdata 0x0080FF00 -> lsu_rdata 0xFFFFFF80; same with LBU -> 0x00000080
//  4 LW addr 0x206 -> lsu_misalign pulse, mem_req never asserted, lsu_stall 0
//  5 LW with no ack, TIMEOUT_CYCLES=16 -> mem_req 16 cycles, lsu_err pulse, lsu_rdata 0, IDLE
//  6 reset_n low during REQ -> mem_req/lsu_stall 0 same cycle; after release, ack ignored

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and encode helpers for the memory-stage load/store unit.
// Size decode treats every undefined funct3 as a word access.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic lsu_size_e size_of(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: size_of = SZ_B;
            F3_H, F3_HU: size_of = SZ_H;
            default:     size_of = SZ_W;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (size_of(f3))
            SZ_H:    is_misaligned = a[0];
            SZ_W:    is_misaligned = (a != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_wstrb(input logic [2:0] f3, input logic [1:0] a);
        case (size_of(f3))
            SZ_B:    store_wstrb = 4'b0001 << a;
            SZ_H:    store_wstrb = a[1] ? 4'b1100 : 4'b0011;
            default: store_wstrb = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (size_of(f3))
            SZ_B:    store_wdata = {4{d[7:0]}};
            SZ_H:    store_wdata = {2{d[15:0]}};
            default: store_wdata = d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed lane of a read word and sign/zero-extends it.
// funct3[2] set means unsigned (LBU/LHU).
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sign_ext;

    always_comb begin
        byte_sel = 8'h00;
        case (addr_i)
            2'd0: byte_sel = word_i[7:0];
            2'd1: byte_sel = word_i[15:8];
            2'd2: byte_sel = word_i[23:16];
            2'd3: byte_sel = word_i[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
        sign_ext = ~funct3_i[2];

        case (size_of(funct3_i))
            SZ_B:    data_o = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SZ_H:    data_o = {{16{sign_ext & half_sel[15]}}, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-stage LSU: one req/ack bus transaction per load/store, with
// misalignment and timeout reporting and a stall back to the pipeline.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              preg_2_rd_en,
    input  logic              preg_2_wr_en,
    input  logic [31:0]       preg_2_alu_out,
    input  logic [31:0]       preg_2_rdata2,
    input  logic [31:0]       preg_2_inst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       lsu_rdata,
    output logic              lsu_stall,
    output logic              lsu_misalign,
    output logic              lsu_err,
    output lsu_state_e        dbg_state_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic [2:0]        f3_q;
    logic              we_q;
    logic [31:0]       rdata_q, rdata_d;
    logic              tmo_err_q, tmo_err_d;

    logic        capture;
    logic        stall_c;
    logic        misalign_c;
    logic        both_err_c;
    logic [2:0]  f3_in;
    logic [31:0] load_data;
    logic        unused_inst;

    assign f3_in       = preg_2_inst[14:12];
    assign unused_inst = ^{preg_2_inst[31:15], preg_2_inst[11:0]};

    lsu_load_align u_align (
        .word_i   (mem_rdata),
        .addr_i   (addr_q[1:0]),
        .funct3_i (f3_q),
        .data_o   (load_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        tmo_err_d  = 1'b0;
        capture    = 1'b0;
        stall_c    = 1'b0;
        misalign_c = 1'b0;
        both_err_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (preg_2_rd_en && preg_2_wr_en) begin
                    both_err_c = 1'b1;
                end else if (preg_2_rd_en ^ preg_2_wr_en) begin
                    if (is_misaligned(f3_in, preg_2_alu_out[1:0])) begin
                        misalign_c = 1'b1;
                    end else begin
                        capture = 1'b1;
                        stall_c = 1'b1;
                        cnt_d   = '0;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                stall_c = 1'b1;
                if (mem_ack) begin
                    if (!we_q) rdata_d = load_data;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    tmo_err_d = 1'b1;
                    rdata_d   = '0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // preg_2 still shows the finished instruction; never re-accept it here.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            f3_q      <= '0;
            we_q      <= 1'b0;
            rdata_q   <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            tmo_err_q <= tmo_err_d;
            if (capture) begin
                addr_q  <= preg_2_alu_out[ADDR_W-1:0];
                wdata_q <= store_wdata(f3_in, preg_2_rdata2);
                wstrb_q <= preg_2_wr_en ? store_wstrb(f3_in, preg_2_alu_out[1:0]) : 4'b0000;
                f3_q    <= f3_in;
                we_q    <= preg_2_wr_en;
            end
        end
    end

    // Bus outputs are driven only while the request is live.
    assign mem_req   = (state_q == REQ);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = mem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wdata = mem_req ? wdata_q : '0;
    assign mem_wstrb = mem_req ? wstrb_q : 4'b0000;

    // Combinational flags are masked so every output reads 0 while reset is held.
    assign lsu_stall    = stall_c & reset_n;
    assign lsu_misalign = misalign_c & reset_n;
    assign lsu_err      = (both_err_c & reset_n) | tmo_err_q;
    assign lsu_rdata    = rdata_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: stores, loads, misalignment, errors,
// timeout and mid-transaction reset, each with hand-computed expectations.
module tb_lsu_mem_stage;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] alu_out = '0;
    logic [31:0] rdata2 = '0;
    logic [31:0] inst = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] lsu_rdata;
    logic        lsu_stall;
    logic        lsu_misalign;
    logic        lsu_err;
    lsu_state_e  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // observations from the most recent run_access
    int          obs_stall, obs_req, obs_mis, obs_err;
    logic [31:0] obs_addr, obs_wdata, obs_rdata;
    logic [3:0]  obs_wstrb;
    logic        obs_we;
    lsu_state_e  obs_final;

    always #5 clk = ~clk;

    lsu_mem_stage #(.TIMEOUT_CYCLES(16), .ADDR_W(32)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .preg_2_rd_en   (rd_en),
        .preg_2_wr_en   (wr_en),
        .preg_2_alu_out (alu_out),
        .preg_2_rdata2  (rdata2),
        .preg_2_inst    (inst),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .lsu_rdata      (lsu_rdata),
        .lsu_stall      (lsu_stall),
        .lsu_misalign   (lsu_misalign),
        .lsu_err        (lsu_err),
        .dbg_state_o    (dbg_state)
    );

    task automatic clear_preg();
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        alu_out = '0;
        rdata2  = '0;
        inst    = '0;
    endtask

    // Drives one MEM-stage instruction, acks on REQ cycle ack_at (-1 = never),
    // and records what the DUT did until it has been idle for a few cycles.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] data, input logic [2:0] f3,
                              input logic [31:0] rdata, input int ack_at);
        bit cleared = 1'b0;
        bit hung = 1'b1;
        int post = 0;
        obs_stall = 0; obs_req = 0; obs_mis = 0; obs_err = 0;
        obs_addr = '0; obs_wdata = '0; obs_wstrb = '0; obs_we = 1'b0;
        obs_rdata = 32'h5A5A5A5A;
        @(posedge clk);
        #1;
        rd_en     = rd;
        wr_en     = wr;
        alu_out   = addr;
        rdata2    = data;
        inst      = {17'b0, f3, 12'b0};
        mem_rdata = rdata;
        mem_ack   = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (lsu_stall) obs_stall++;
            if (lsu_misalign) obs_mis++;
            if (lsu_err) obs_err++;
            if (mem_req) begin
                if (obs_req == 0) begin
                    obs_addr  = mem_addr;
                    obs_wdata = mem_wdata;
                    obs_wstrb = mem_wstrb;
                    obs_we    = mem_we;
                end
                if (obs_req == ack_at) mem_ack = 1'b1;
                obs_req++;
            end
            if (dbg_state == DONE) obs_rdata = lsu_rdata;
            obs_final = dbg_state;
            if (cleared) begin
                post++;
                if (post == 3) begin
                    hung = 1'b0;
                    break;
                end
            end else if (dbg_state == DONE || (dbg_state == IDLE && !lsu_stall)) begin
                clear_preg();
                cleared = 1'b1;
            end
        end
        n_checks++;
        if (hung) begin
            n_fail++;
            $display("FAIL access_bound: addr %h did not return to idle within 60 cycles", addr);
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({mem_req, mem_we, lsu_stall, lsu_misalign, lsu_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {mem_req, mem_we, lsu_stall, lsu_misalign, lsu_err});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, lsu_rdata} !== 96'b0 || mem_wstrb !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_buses: addr %h wdata %h rdata %h wstrb %b expected all zero",
                     mem_addr, mem_wdata, lsu_rdata, mem_wstrb);
        end
        n_checks++;
        if (dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_store_word();
        run_access(1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, F3_W, 32'h0, 0);
        n_checks++;
        if (obs_addr !== 32'h0000_0100 || obs_we !== 1'b1) begin
            n_fail++;
            $display("FAIL sw_addr_we: got %h/%b expected 00000100/1", obs_addr, obs_we);
        end
        n_checks++;
        if (obs_wstrb !== 4'b1111 || obs_wdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL sw_lanes: got %b/%h expected 1111/deadbeef", obs_wstrb, obs_wdata);
        end
        n_checks++;
        if (obs_stall != 2 || obs_req != 1) begin
            n_fail++;
            $display("FAIL sw_latency: stall %0d req %0d expected 2 and 1", obs_stall, obs_req);
        end
        n_checks++;
        if (obs_err != 0 || obs_mis != 0 || obs_final !== IDLE) begin
            n_fail++;
            $display("FAIL sw_clean: err %0d mis %0d state %0d expected 0 0 0",
                     obs_err, obs_mis, obs_final);
        end
    endtask

    task automatic test_store_sub_word();
        run_access(1'b0, 1'b1, 32'h0000_0103, 32'h0000_00A5, F3_B, 32'h0, 0);
        n_checks++;
        if (obs_wdata !== 32'hA5A5_A5A5 || obs_wstrb !== 4'b1000 || obs_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL sb_103: got %h/%b/%h expected a5a5a5a5/1000/00000100",
                     obs_wdata, obs_wstrb, obs_addr);
        end
        run_access(1'b0, 1'b1, 32'h0000_0101, 32'h1122_3344, F3_B, 32'h0, 0);
        n_checks++;
        if (obs_wdata !== 32'h4444_4444 || obs_wstrb !== 4'b0010) begin
            n_fail++;
            $display("FAIL sb_101: got %h/%b expected 44444444/0010", obs_wdata, obs_wstrb);
        end
        run_access(1'b0, 1'b1, 32'h0000_0102, 32'h1234_ABCD, F3_H, 32'h0, 0);
        n_checks++;
        if (obs_wdata !== 32'hABCD_ABCD || obs_wstrb !== 4'b1100) begin
            n_fail++;
            $display("FAIL sh_102: got %h/%b expected abcdabcd/1100", obs_wdata, obs_wstrb);
        end
        run_access(1'b0, 1'b1, 32'h0000_0100, 32'h1234_ABCD, F3_H, 32'h0, 0);
        n_checks++;
        if (obs_wstrb !== 4'b0011) begin
            n_fail++;
            $display("FAIL sh_100: wstrb %b expected 0011", obs_wstrb);
        end
    endtask

    task automatic test_load_byte();
        run_access(1'b1, 1'b0, 32'h0000_0202, 32'h0, F3_B, 32'h0080_FF00, 0);
        n_checks++;
        if (obs_rdata !== 32'hFFFF_FF80) begin
            n_fail++;
            $display("FAIL lb_202: got %h expected ffffff80", obs_rdata);
        end
        n_checks++;
        if (obs_we !== 1'b0 || obs_wstrb !== 4'b0000 || obs_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL lb_bus: we %b wstrb %b addr %h expected 0/0000/00000200",
                     obs_we, obs_wstrb, obs_addr);
        end
        run_access(1'b1, 1'b0, 32'h0000_0202, 32'h0, F3_BU, 32'h0080_FF00, 0);
        n_checks++;
        if (obs_rdata !== 32'h0000_0080) begin
            n_fail++;
            $display("FAIL lbu_202: got %h expected 00000080", obs_rdata);
        end
        run_access(1'b1, 1'b0, 32'h0000_0201, 32'h0, F3_B, 32'h0080_FF00, 0);
        n_checks++;
        if (obs_rdata !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL lb_201: got %h expected ffffffff", obs_rdata);
        end
    endtask

    task automatic test_load_half_word();
        run_access(1'b1, 1'b0, 32'h0000_0202, 32'h0, F3_H, 32'h8001_0000, 0);
        n_checks++;
        if (obs_rdata !== 32'hFFFF_8001) begin
            n_fail++;
            $display("FAIL lh_202: got %h expected ffff8001", obs_rdata);
        end
        run_access(1'b1, 1'b0, 32'h0000_0202, 32'h0, F3_HU, 32'h8001_0000, 0);
        n_checks++;
        if (obs_rdata !== 32'h0000_8001) begin
            n_fail++;
            $display("FAIL lhu_202: got %h expected 00008001", obs_rdata);
        end
        run_access(1'b1, 1'b0, 32'h0000_0204, 32'h0, F3_W, 32'h1234_5678, 2);
        n_checks++;
        if (obs_rdata !== 32'h1234_5678 || obs_addr !== 32'h204) begin
            n_fail++;
            $display("FAIL lw_204: got %h/%h expected 12345678/00000204", obs_rdata, obs_addr);
        end
        n_checks++;
        if (obs_stall != 4 || obs_req != 3) begin
            n_fail++;
            $display("FAIL lw_late_ack: stall %0d req %0d expected 4 and 3", obs_stall, obs_req);
        end
        run_access(1'b1, 1'b0, 32'h0000_0208, 32'h0, 3'b011, 32'hCAFE_F00D, 0);
        n_checks++;
        if (obs_rdata !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL undef_f3_word: got %h expected cafef00d", obs_rdata);
        end
    endtask

    task automatic test_misalign();
        run_access(1'b1, 1'b0, 32'h0000_0206, 32'h0, F3_W, 32'h0, 0);
        n_checks++;
        if (obs_mis != 1 || obs_req != 0 || obs_stall != 0 || obs_err != 0) begin
            n_fail++;
            $display("FAIL lw_206_misalign: mis %0d req %0d stall %0d err %0d expected 1 0 0 0",
                     obs_mis, obs_req, obs_stall, obs_err);
        end
        run_access(1'b1, 1'b0, 32'h0000_0201, 32'h0, F3_HU, 32'h0, 0);
        n_checks++;
        if (obs_mis != 1 || obs_req != 0) begin
            n_fail++;
            $display("FAIL lhu_201_misalign: mis %0d req %0d expected 1 0", obs_mis, obs_req);
        end
        run_access(1'b0, 1'b1, 32'h0000_0102, 32'hFFFF_FFFF, 3'b111, 32'h0, 0);
        n_checks++;
        if (obs_mis != 1 || obs_req != 0 || obs_stall != 0) begin
            n_fail++;
            $display("FAIL undef_store_misalign: mis %0d req %0d stall %0d expected 1 0 0",
                     obs_mis, obs_req, obs_stall);
        end
        n_checks++;
        if (lsu_rdata !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL misalign_keeps_rdata: got %h expected cafef00d", lsu_rdata);
        end
    endtask

    task automatic test_both_enables();
        run_access(1'b1, 1'b1, 32'h0000_0100, 32'h0, F3_W, 32'h0, 0);
        n_checks++;
        if (obs_err != 1 || obs_req != 0 || obs_stall != 0 || obs_mis != 0) begin
            n_fail++;
            $display("FAIL rd_wr_both: err %0d req %0d stall %0d mis %0d expected 1 0 0 0",
                     obs_err, obs_req, obs_stall, obs_mis);
        end
    endtask

    task automatic test_timeout();
        run_access(1'b1, 1'b0, 32'h0000_0300, 32'h0, F3_W, 32'h7777_7777, -1);
        n_checks++;
        if (obs_req != 16) begin
            n_fail++;
            $display("FAIL timeout_req_cycles: got %0d expected 16", obs_req);
        end
        n_checks++;
        if (obs_err != 1 || obs_stall != 17) begin
            n_fail++;
            $display("FAIL timeout_err: err %0d stall %0d expected 1 and 17", obs_err, obs_stall);
        end
        n_checks++;
        if (obs_rdata !== 32'h0 || obs_final !== IDLE) begin
            n_fail++;
            $display("FAIL timeout_result: rdata %h state %0d expected 00000000 and 0",
                     obs_rdata, obs_final);
        end
    endtask

    task automatic test_reset_mid_req();
        @(posedge clk);
        #1;
        rd_en   = 1'b1;
        alu_out = 32'h0000_0400;
        inst    = {17'b0, F3_W, 12'b0};
        mem_rdata = 32'h1357_9BDF;
        @(posedge clk);
        #1;
        n_checks++;
        if (mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_enter_req: mem_req %b expected 1", mem_req);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || lsu_stall !== 1'b0 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL rst_mid_drop: req %b stall %b state %0d expected 0 0 0",
                     mem_req, lsu_stall, dbg_state);
        end
        clear_preg();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        mem_ack = 1'b1;
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b0 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL rst_stray_ack: req %b state %0d expected 0 0", mem_req, dbg_state);
        end
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dbg_state !== IDLE || lsu_rdata !== 32'h0 || lsu_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_after_ack: state %0d rdata %h err %b expected 0 00000000 0",
                     dbg_state, lsu_rdata, lsu_err);
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_store_sub_word();
        test_load_byte();
        test_load_half_word();
        test_misalign();
        test_both_enables();
        test_timeout();
        test_reset_mid_req();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
